// File: rtl/cpu_multicycle.sv
// Multi-cycle RV32I-subset core sharing one req/ack memory port.
// FSM-sequenced datapath with halt-on-trap and a retired-instruction counter.
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [31:0]      pc,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, HALT
  } state_t;

  state_t state, state_d;

  logic [31:0] ir, a, b, imm, val;
  logic [31:0] rf [32];
  logic [31:0] pc_d, val_d, imm_d;
  logic [31:0] ls_addr, alu_y, alu_r;
  logic [1:0]  cause_d;
  logic        retire, rf_we, zero, taken;
  logic        alt, done, legal;
  logic        is_op, is_opi, is_ld, is_st;
  logic        is_br, is_jal, is_lui, is_sys;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;

  assign opc = ir[6:0];
  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  assign is_op  = opc == 7'b0110011;
  assign is_opi = opc == 7'b0010011;
  assign is_ld  = opc == 7'b0000011;
  assign is_st  = opc == 7'b0100011;
  assign is_br  = opc == 7'b1100011;
  assign is_jal = opc == 7'b1101111;
  assign is_lui = opc == 7'b0110111;
  assign is_sys = opc == 7'b1110011;
  assign legal  = is_op | is_opi | is_ld | is_st |
                  is_br | is_jal | is_lui | is_sys;

  assign done   = mem_req & mem_ack;
  assign halted = state == HALT;

  function automatic logic [31:0] alu(
    input logic [2:0]  op,
    input logic        sub,
    input logic [31:0] x,
    input logic [31:0] y
  );
    logic [31:0] r;
    unique case (op)
      3'b000:  r = sub ? x - y : x + y;
      3'b001:  r = x << y[4:0];
      3'b010:  r = {31'b0, $signed(x) < $signed(y)};
      3'b011:  r = {31'b0, x < y};
      3'b100:  r = x ^ y;
      3'b101:  r = sub ? 32'($signed(x) >>> y[4:0])
                       : x >> y[4:0];
      3'b110:  r = x | y;
      default: r = x & y;
    endcase
    return r;
  endfunction

  always_comb begin
    imm_d = {{20{ir[31]}}, ir[31:20]};
    unique case (1'b1)
      is_st:  imm_d = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      is_br:  imm_d = {{19{ir[31]}}, ir[31], ir[7],
                       ir[30:25], ir[11:8], 1'b0};
      is_jal: imm_d = {{11{ir[31]}}, ir[31], ir[19:12],
                       ir[20], ir[30:21], 1'b0};
      is_lui: imm_d = {ir[31:12], 12'b0};
      default: ;
    endcase
  end

  // srai/sra and sub share ir[30]; it means nothing for other OP-IMM
  assign alt     = ir[30] & (is_op | (f3 == 3'b101));
  assign alu_y   = is_op ? b : imm;
  assign alu_r   = alu(f3, alt, a, alu_y);
  assign ls_addr = a + imm;
  assign zero    = (a - b) == 32'd0;
  assign taken   = f3[0] ? ~zero : zero;

  always_comb begin
    state_d = state;
    pc_d    = pc;
    val_d   = val;
    cause_d = trap_cause;
    retire  = 1'b0;
    rf_we   = 1'b0;
    unique case (state)
      FETCH: if (done) state_d = DECODE;
      DECODE: begin
        if (!legal) begin
          state_d = HALT;
          cause_d = 2'd1;
        end else if (is_sys) begin
          state_d = HALT;
          cause_d = 2'd3;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (is_ld | is_st) begin
          if (ls_addr[1:0] != 2'b00) begin
            state_d = HALT;
            cause_d = 2'd2;
          end else begin
            state_d = MEM;
          end
        end else if (is_br) begin
          pc_d    = taken ? pc + imm : pc + 32'd4;
          retire  = 1'b1;
          state_d = FETCH;
        end else if (is_jal) begin
          val_d   = pc + 32'd4;
          pc_d    = pc + imm;
          state_d = WB;
        end else if (is_lui) begin
          val_d   = imm;
          state_d = WB;
        end else begin
          val_d   = alu_r;
          state_d = WB;
        end
      end
      MEM: begin
        if (done) begin
          if (is_st) begin
            pc_d    = pc + 32'd4;
            retire  = 1'b1;
            state_d = FETCH;
          end else begin
            val_d   = mem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we   = rd != 5'd0;
        if (!is_jal) pc_d = pc + 32'd4;
        retire  = 1'b1;
        state_d = FETCH;
      end
      HALT: ;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_d;
  end

  // bus outputs are set up from the next state so a request is live on entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      ir         <= '0;
      a          <= '0;
      b          <= '0;
      imm        <= '0;
      val        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      trap_cause <= '0;
      instret    <= '0;
    end else begin
      pc         <= pc_d;
      val        <= val_d;
      trap_cause <= cause_d;
      mem_req    <= (state_d == FETCH) | (state_d == MEM);
      mem_we     <= (state_d == MEM) & is_st;
      if (state_d == FETCH) begin
        mem_addr <= pc_d;
      end else if (state == EXEC && state_d == MEM) begin
        mem_addr  <= ls_addr;
        mem_wdata <= b;
      end
      if (state == FETCH && done) ir <= mem_rdata;
      if (state == DECODE) begin
        a   <= (rs1 == 5'd0) ? 32'd0 : rf[rs1];
        b   <= (rs2 == 5'd0) ? 32'd0 : rf[rs2];
        imm <= imm_d;
      end
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we) rf[rd] <= val;
  end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle with a wait-state memory model.
// Results are observed through store traffic and the core status ports.
module tb_cpu_multicycle;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] pc;
  logic        halted;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  always #5 clk = ~clk;

  cpu_multicycle #(
    .RESET_PC (32'h0000_0000),
    .CNT_W    (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .pc         (pc),
    .halted     (halted),
    .trap_cause (trap_cause),
    .instret    (instret)
  );

  logic [31:0] mem [64];
  logic [31:0] wa [$];
  logic [31:0] wd [$];
  int          ack_dly = 0;
  int          wcnt = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic        chk_stable = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    logic [31:0] d, s, v;
    d = rd; s = rs1; v = imm;
    return {v[11:0], s[4:0], 3'b000, d[4:0], 7'h13};
  endfunction

  function automatic logic [31:0] lw(int rd, int rs1, int imm);
    logic [31:0] d, s, v;
    d = rd; s = rs1; v = imm;
    return {v[11:0], s[4:0], 3'b010, d[4:0], 7'h03};
  endfunction

  function automatic logic [31:0] sw(int rs2, int rs1, int imm);
    logic [31:0] t, s, v;
    t = rs2; s = rs1; v = imm;
    return {v[11:5], t[4:0], s[4:0], 3'b010, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] br(int f3, int rs1, int rs2, int imm);
    logic [31:0] f, s, t, v;
    f = f3; s = rs1; t = rs2; v = imm;
    return {v[12], v[10:5], t[4:0], s[4:0], f[2:0],
            v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] jal(int rd, int imm);
    logic [31:0] d, v;
    d = rd; v = imm;
    return {v[20], v[10:1], v[11], v[19:12], d[4:0], 7'h6f};
  endfunction

  // memory model: ack after ack_dly wait cycles, data at negedge
  always @(negedge clk) begin
    mem_ack   = mem_req && (wcnt >= ack_dly);
    mem_rdata = mem[mem_addr[7:2]];
  end

  always @(posedge clk) begin
    if (!rst) begin
      wcnt = 0;
      pend = 1'b0;
    end else begin
      if (chk_stable && pend) begin
        chk("req_hold", 32'(mem_req), 32'd1);
        chk("addr_hold", mem_addr, paddr);
      end
      pend  = mem_req && !mem_ack;
      paddr = mem_addr;
      if (mem_req && mem_ack) begin
        wcnt = 0;
        if (mem_we) begin
          mem[mem_addr[7:2]] = mem_wdata;
          wa.push_back(mem_addr);
          wd.push_back(mem_wdata);
        end
      end else if (mem_req) begin
        wcnt++;
      end
    end
  end

  task automatic clr_mem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic load_p1();
    clr_mem();
    mem[0] = addi(1, 0, 5);
    mem[1] = addi(2, 1, -7);
    mem[2] = sw(2, 0, 8);
    mem[3] = lw(3, 0, 8);
    mem[4] = sw(3, 0, 12);
    mem[5] = lw(4, 0, 6);
  endtask

  task automatic load_p2();
    clr_mem();
    mem[0] = br(1, 0, 0, 64);
    mem[1] = addi(0, 0, 1);
    mem[2] = sw(0, 0, 48);
    mem[3] = jal(1, 8);
    mem[4] = 32'h0000_0073;
    mem[5] = sw(1, 0, 52);
    mem[6] = br(0, 0, 0, -8);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    wa.delete();
    wd.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_rise", 32'(mem_req), 32'd1);
  endtask

  task automatic run_halt();
    int n = 0;
    while (!halted && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("halted", 32'(halted), 32'd1);
  endtask

  task automatic chk_p1_writes(input string t);
    chk({t, "_nw"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({t, "_wa0"}, wa[0], 32'd8);
      chk({t, "_wd0"}, wd[0], 32'hFFFF_FFFE);
      chk({t, "_wa1"}, wa[1], 32'd12);
      chk({t, "_wd1"}, wd[1], 32'hFFFF_FFFE);
    end
  endtask

  initial begin
    // reset state
    load_p1();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_halt", 32'(halted), 32'd0);
    chk("rst_cause", 32'(trap_cause), 32'd0);
    chk("rst_inst", instret, 32'd0);
    rst = 1'b1;

    // zero-wait ALU pair, store/load, misaligned load
    wait_req();
    chk("t1_faddr", mem_addr, 32'd0);
    repeat (7) @(posedge clk);
    #1 chk("t1_inst7", instret, 32'd1);
    @(posedge clk);
    #1 chk("t1_inst8", instret, 32'd2);
    chk("t1_pc8", pc, 32'd8);
    run_halt();
    chk_p1_writes("t1");
    chk("t1_cause", 32'(trap_cause), 32'd2);
    chk("t1_pc", pc, 32'd20);
    chk("t1_inst", instret, 32'd5);
    chk("t1_req", 32'(mem_req), 32'd0);

    // three wait states on every access
    load_p1();
    ack_dly = 3;
    do_reset();
    chk_stable = 1'b1;
    wait_req();
    repeat (13) @(posedge clk);
    #1 chk("t2_inst13", instret, 32'd1);
    @(posedge clk);
    #1 chk("t2_inst14", instret, 32'd2);
    chk("t2_pc14", pc, 32'd8);
    run_halt();
    chk_stable = 1'b0;
    chk_p1_writes("t2");
    chk("t2_cause", 32'(trap_cause), 32'd2);
    chk("t2_inst", instret, 32'd5);

    // branches, jal link, x0 write, ecall
    load_p2();
    ack_dly = 0;
    do_reset();
    wait_req();
    repeat (3) @(posedge clk);
    #1 chk("t4_bne_pc", pc, 32'd4);
    chk("t4_bne_inst", instret, 32'd1);
    begin
      int n = 0;
      while (pc != 32'd24 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t4_at_beq", pc, 32'd24);
    repeat (2) @(posedge clk);
    #1 chk("t4_beq2", pc, 32'd24);
    @(posedge clk);
    #1 chk("t4_beq3", pc, 32'd16);
    chk("t4_beq_inst", instret, 32'd6);
    run_halt();
    chk("t4_cause", 32'(trap_cause), 32'd3);
    chk("t4_pc", pc, 32'd16);
    chk("t4_inst", instret, 32'd6);
    chk("t4_nw", 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk("t4_wa0", wa[0], 32'd48);
      chk("t4_x0", wd[0], 32'd0);
      chk("t4_wa1", wa[1], 32'd52);
      chk("t4_link", wd[1], 32'd16);
    end

    // illegal opcode, then hold in HALT
    clr_mem();
    mem[0] = addi(1, 0, 1);
    mem[1] = 32'hFFFF_FFFF;
    do_reset();
    run_halt();
    chk("t5_cause", 32'(trap_cause), 32'd1);
    chk("t5_pc", pc, 32'd4);
    chk("t5_inst", instret, 32'd1);
    repeat (5) @(negedge clk);
    chk("t5_hold_pc", pc, 32'd4);
    chk("t5_hold_inst", instret, 32'd1);
    chk("t5_hold_req", 32'(mem_req), 32'd0);
    chk("t5_hold_cause", 32'(trap_cause), 32'd1);

    // ecall as first instruction
    clr_mem();
    mem[0] = 32'h0000_0073;
    do_reset();
    run_halt();
    chk("t5e_cause", 32'(trap_cause), 32'd3);
    chk("t5e_pc", pc, 32'd0);
    chk("t5e_inst", instret, 32'd0);
    chk("t5e_req", 32'(mem_req), 32'd0);

    // reset in the middle of a stalled store
    load_p1();
    ack_dly = 10;
    do_reset();
    begin
      int n = 0;
      while (!(mem_req && mem_we) && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t6_in_mem", 32'(mem_we), 32'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("t6_req", 32'(mem_req), 32'd0);
    chk("t6_we", 32'(mem_we), 32'd0);
    chk("t6_pc", pc, 32'd0);
    chk("t6_inst", instret, 32'd0);
    chk("t6_nw", 32'(wa.size()), 32'd0);
    @(negedge clk);
    ack_dly = 0;
    rst = 1'b1;
    wait_req();
    chk("t6_faddr", mem_addr, 32'd0);
    chk("t6_fwe", 32'(mem_we), 32'd0);
    run_halt();
    chk("t6_cause", 32'(trap_cause), 32'd2);
    chk("t6_end_inst", instret, 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
